// File: rtl/wb_uart_tx_if.sv
// -----------------------------------------------------------------------------
// wb_uart_tx_if
//   Wishbone pipelined bus bundle for the wb_uart_tx serial transmitter.
//
//   Signals:
//     adr    [15:0]  byte address (responder decodes adr[2:1] only)
//     cyc            bus cycle
//     stb            strobe
//     we             write enable
//     dat_i  [15:0]  write data (master -> responder)
//     dat_o  [15:0]  read data  (responder -> master), registered
//     ack            acknowledge, registered
//     stall          pipeline stall, combinational
//
//   Modports:
//     master : drives adr/cyc/stb/we/dat_i, observes dat_o/ack/stall
//     slave  : observes adr/cyc/stb/we/dat_i, drives dat_o/ack/stall
// -----------------------------------------------------------------------------
interface wb_uart_tx_if;
  logic [15:0] adr;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [15:0] dat_i;
  logic [15:0] dat_o;
  logic        ack;
  logic        stall;

  modport master (
    output adr, cyc, stb, we, dat_i,
    input  dat_o, ack, stall
  );

  modport slave (
    input  adr, cyc, stb, we, dat_i,
    output dat_o, ack, stall
  );
endinterface

// File: rtl/wb_uart_tx.sv
// -----------------------------------------------------------------------------
// wb_uart_tx
//   Wishbone pipelined responder that queues bytes in a write FIFO and shifts
//   them out LSB-first on an asynchronous serial line (1 start, 8 data, 1 stop).
//
//   Parameters:
//     FIFO_DEPTH  TX FIFO entries, power of two in 2..256
//     BAUD_RESET  reset value of BAUD; each bit lasts BAUD+1 clocks
//
//   Ports:
//     clk   system clock
//     rst   synchronous active-high reset
//     wb    Wishbone bus (slave modport): adr, cyc, stb, we, dat_i,
//           dat_o, ack, stall
//     txd   serial output, idle high
//     irq   (only with WB_UART_TX_IRQ_EN) registered interrupt request
//
//   Register map (adr[2:1]):
//     0 DATA    write pushes dat_i[7:0]; reads 0
//     1 STATUS  RO: [0] busy, [1] FIFO empty, [2] FIFO full, [15:8] level
//     2 BAUD    RW, 16 bits
//     3 IEN     with WB_UART_TX_IRQ_EN: RW [1:0]; otherwise reserved (reads 0)
//
//   Optional feature macro: WB_UART_TX_IRQ_EN
//     irq <= (IEN[0] & fifo_empty) | (IEN[1] & fifo_empty & ~busy)
// -----------------------------------------------------------------------------
module wb_uart_tx #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] BAUD_RESET = 16'd433
) (
  input  logic          clk,
  input  logic          rst,
  wb_uart_tx_if.slave   wb,
  output logic          txd
`ifdef WB_UART_TX_IRQ_EN
  ,
  output logic          irq
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_BAUD   = 2'd2,
    REG_IEN    = 2'd3
  } reg_sel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  reg_sel_e    sel;
  logic        req;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        busy;
  logic [15:0] baud_reg;
  logic [15:0] rd_mux;
  logic [15:0] status;
  logic [15:0] level_w;

  assign sel = reg_sel_e'(wb.adr[2:1]);

  // Only a DATA write into a full FIFO stalls; a pop in the same cycle does
  // not release it, keeping stall a pure function of registered state.
  assign wb.stall = wb.cyc & wb.stb & wb.we & (sel == REG_DATA) & fifo_full;
  assign req      = wb.cyc & wb.stb & ~wb.stall;
  assign push     = req & wb.we & (sel == REG_DATA);

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic [7:0]  fifo_head;

  assign fifo_full  = (level == LVL_FULL);
  assign fifo_empty = (level == '0);
  assign fifo_head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wb.dat_i[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter FSM
  // ---------------------------------------------------------------------------
  state_e      state;
  state_e      state_n;
  logic [15:0] baud_cnt;
  logic [15:0] baud_cnt_n;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_idx_n;
  logic [7:0]  shifter;
  logic [7:0]  shifter_n;
  logic        bit_end;

  assign busy    = (state != IDLE);
  assign bit_end = (baud_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shifter  <= shifter_n;
    end
  end

  // The bit counter is reloaded from the live BAUD register only at a bit
  // boundary, so a BAUD write mid-bit takes effect from the next bit.
  always_comb begin
    state_n    = state;
    baud_cnt_n = bit_end ? baud_cnt : baud_cnt - 16'd1;
    bit_idx_n  = bit_idx;
    shifter_n  = shifter;
    pop        = 1'b0;
    txd        = 1'b1;

    case (state)
      IDLE: begin
        txd        = 1'b1;
        baud_cnt_n = baud_cnt;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shifter_n  = fifo_head;
          baud_cnt_n = baud_reg;
          state_n    = START;
        end
      end

      START: begin
        txd = 1'b0;
        if (bit_end) begin
          baud_cnt_n = baud_reg;
          bit_idx_n  = '0;
          state_n    = DATA;
        end
      end

      DATA: begin
        txd = shifter[0];
        if (bit_end) begin
          baud_cnt_n = baud_reg;
          shifter_n  = {1'b0, shifter[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end

      STOP: begin
        txd = 1'b1;
        if (bit_end) begin
          // Chain straight into the next frame when a byte is waiting.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shifter_n  = fifo_head;
            baud_cnt_n = baud_reg;
            state_n    = START;
          end else begin
            state_n = IDLE;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers and bus response
  // ---------------------------------------------------------------------------
`ifdef WB_UART_TX_IRQ_EN
  logic [1:0] ien;
`endif

  assign level_w = 16'(level);
  assign status  = {level_w[7:0], 5'b0, fifo_full, fifo_empty, busy};

  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_DATA:   rd_mux = '0;
      REG_STATUS: rd_mux = status;
      REG_BAUD:   rd_mux = baud_reg;
`ifdef WB_UART_TX_IRQ_EN
      REG_IEN:    rd_mux = {14'b0, ien};
`else
      REG_IEN:    rd_mux = '0;
`endif
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb.ack   <= 1'b0;
      wb.dat_o <= '0;
      baud_reg <= BAUD_RESET;
    end else begin
      wb.ack <= req;
      if (req && !wb.we) begin
        wb.dat_o <= rd_mux;
      end
      if (req && wb.we && (sel == REG_BAUD)) begin
        baud_reg <= wb.dat_i;
      end
    end
  end

`ifdef WB_UART_TX_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ien <= '0;
      irq <= 1'b0;
    end else begin
      if (req && wb.we && (sel == REG_IEN)) begin
        ien <= wb.dat_i[1:0];
      end
      irq <= (ien[0] & fifo_empty) | (ien[1] & fifo_empty & ~busy);
    end
  end
`endif

  // Address bits outside adr[2:1] and the upper level bits are intentionally
  // ignored.
  logic unused_bits;
  assign unused_bits = ^{wb.adr[15:3], wb.adr[0], level_w[15:8]};

endmodule

// File: tb/tb_wb_uart_tx.sv
module tb_wb_uart_tx;

  logic clk = 1'b0;
  logic rst;
  logic txd;
`ifdef WB_UART_TX_IRQ_EN
  logic irq;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;

  wb_uart_tx_if bus ();

  wb_uart_tx #(
    .FIFO_DEPTH (16),
    .BAUD_RESET (16'd433)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus),
    .txd (txd)
`ifdef WB_UART_TX_IRQ_EN
    ,
    .irq (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single non-pipelined transfer; returns at the sample point where ack shows.
  task automatic xfer(input logic w, input logic [15:0] a, input logic [15:0] d,
                      output logic [15:0] rd);
    int unsigned n = 0;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = w; bus.adr = a; bus.dat_i = d;
    @(negedge clk);
    while (bus.stall && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("xfer_stall_bound", 32'(n < 200), 32'd1);
    @(posedge clk);
    #1;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    check("xfer_ack", 32'(bus.ack), 32'd1);
    rd = bus.dat_o;
  endtask

  // Checks txd every clock for one frame starting at the first START cycle.
  // Bits before index sw last len0 clocks, the rest len1. Optionally issues
  // one bus transfer at frame cycle op_at.
  task automatic check_frame(input logic [7:0] d, input int unsigned len0,
                             input int unsigned len1, input int unsigned sw,
                             input int op_at, input logic op_we,
                             input logic [15:0] op_adr, input logic [15:0] op_dat);
    int idx = 0;
    logic issued = 1'b0;
    logic exp_bit;
    int unsigned len;
    for (int b = 0; b < 10; b++) begin
      if (b == 0) exp_bit = 1'b0;
      else if (b == 9) exp_bit = 1'b1;
      else exp_bit = d[b-1];
      len = (b < int'(sw)) ? len0 : len1;
      for (int unsigned c = 0; c < len; c++) begin
        check($sformatf("txd_%02h_bit%0d_clk%0d", d, b, c), 32'(txd), 32'(exp_bit));
        if (idx == op_at) begin
          bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = op_we;
          bus.adr = op_adr; bus.dat_i = op_dat;
          issued = 1'b1;
        end
        tick();
        if (issued) begin
          bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
          check("frame_op_ack", 32'(bus.ack), 32'd1);
          if (!op_we) check("frame_status_busy", 32'(bus.dat_o[0]), 32'd1);
          issued = 1'b0;
        end
        idx++;
      end
    end
  endtask

  initial begin
    logic [15:0] rd;
    int unsigned n;
    logic low_seen;

    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.adr = '0; bus.dat_i = '0;
    rst = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_dat_o", 32'(bus.dat_o), 32'h0);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_stall", 32'(bus.stall), 32'd0);
`ifdef WB_UART_TX_IRQ_EN
    check("rst_irq", 32'(irq), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Register reads after reset
    xfer(1'b0, 16'h0002, 16'h0, rd);
    check("status_reset", 32'(rd), 32'h0002);
    tick();
    check("ack_single_cycle", 32'(bus.ack), 32'd0);
    xfer(1'b0, 16'h0004, 16'h0, rd);
    check("baud_reset", 32'(rd), 32'd433);
    xfer(1'b0, 16'h0000, 16'h0, rd);
    check("data_reads_zero", 32'(rd), 32'h0);
    xfer(1'b1, 16'h0003, 16'hFFFF, rd);  // adr[0] ignored: STATUS, write ignored
    xfer(1'b0, 16'h0003, 16'h0, rd);
    check("status_write_ignored", 32'(rd), 32'h0002);
    xfer(1'b1, 16'h0006, 16'hFFFF, rd);
    xfer(1'b0, 16'h0006, 16'h0, rd);
`ifdef WB_UART_TX_IRQ_EN
    check("ien_readback", 32'(rd), 32'h0003);
    xfer(1'b1, 16'h0006, 16'h0000, rd);
`else
    check("reserved_reads_zero", 32'(rd), 32'h0);
`endif
    check("txd_idle", 32'(txd), 32'd1);

    // 0x55 at BAUD=3, STATUS probed mid-frame
    xfer(1'b1, 16'h0004, 16'd3, rd);
    xfer(1'b1, 16'h0000, 16'h0055, rd);
    check("txd_before_start", 32'(txd), 32'd1);
    tick();
    check_frame(8'h55, 4, 4, 10, 10, 1'b0, 16'h0002, 16'h0);
    xfer(1'b0, 16'h0002, 16'h0, rd);
    check("status_after_55", 32'(rd), 32'h0002);

    // 18 pipelined accesses: 17 DATA writes, STATUS read, 18th write stalls
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 16'h0000;
    for (int i = 0; i < 17; i++) begin
      bus.dat_i = 16'(8'h10 + i);
      @(negedge clk);
      check($sformatf("burst_stall_%0d", i), 32'(bus.stall), 32'd0);
      tick();
    end
    bus.we = 1'b0; bus.adr = 16'h0002;
    @(negedge clk);
    check("burst_read_stall", 32'(bus.stall), 32'd0);
    tick();
    check("burst_read_ack", 32'(bus.ack), 32'd1);
    check("status_full", 32'(bus.dat_o), 32'h1005);
    bus.we = 1'b1; bus.adr = 16'h0000; bus.dat_i = 16'h00EE;
    n = 0;
    @(negedge clk);
    while (bus.stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("burst_stall_cycles", n, 32'd24);
    tick();
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    check("burst_18th_ack", 32'(bus.ack), 32'd1);
    repeat (720) tick();
    xfer(1'b0, 16'h0002, 16'h0, rd);
    check("status_drained", 32'(rd), 32'h0002);

    // Back-to-back frames, no idle gap
    xfer(1'b1, 16'h0000, 16'h00A5, rd);
    xfer(1'b1, 16'h0000, 16'h003C, rd);
    check_frame(8'hA5, 4, 4, 10, -1, 1'b0, 16'h0, 16'h0);
    check_frame(8'h3C, 4, 4, 10, -1, 1'b0, 16'h0, 16'h0);
    check("txd_after_pair", 32'(txd), 32'd1);

    // BAUD=7 written during data bit 2 of a BAUD=3 frame
    xfer(1'b1, 16'h0000, 16'h0096, rd);
    tick();
    check_frame(8'h96, 4, 8, 4, 13, 1'b1, 16'h0004, 16'd7);
    xfer(1'b0, 16'h0004, 16'h0, rd);
    check("baud_after_change", 32'(rd), 32'd7);
    xfer(1'b1, 16'h0004, 16'd3, rd);

    // Reset mid-DATA with 3 bytes queued
    xfer(1'b1, 16'h0000, 16'h0000, rd);
    xfer(1'b1, 16'h0000, 16'h0011, rd);
    xfer(1'b1, 16'h0000, 16'h0022, rd);
    xfer(1'b1, 16'h0000, 16'h0033, rd);
    repeat (10) tick();
    check("txd_low_before_rst", 32'(txd), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("txd_after_rst", 32'(txd), 32'd1);
    xfer(1'b0, 16'h0002, 16'h0, rd);
    check("status_after_rst", 32'(rd), 32'h0002);
    xfer(1'b0, 16'h0004, 16'h0, rd);
    check("baud_after_rst", 32'(rd), 32'd433);
    low_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (txd !== 1'b1) low_seen = 1'b1;
      tick();
    end
    check("no_frame_after_rst", 32'(low_seen), 32'd0);

    // BAUD=0: one clock per bit
    xfer(1'b1, 16'h0004, 16'd0, rd);
    xfer(1'b1, 16'h0000, 16'h0081, rd);
    tick();
    check_frame(8'h81, 1, 1, 10, -1, 1'b0, 16'h0, 16'h0);
    xfer(1'b0, 16'h0002, 16'h0, rd);
    check("status_after_baud0", 32'(rd), 32'h0002);

`ifdef WB_UART_TX_IRQ_EN
    // IEN[1]: interrupt on transmitter idle with empty FIFO
    xfer(1'b1, 16'h0006, 16'h0002, rd);
    tick();
    check("irq_idle", 32'(irq), 32'd1);
    xfer(1'b1, 16'h0000, 16'h000F, rd);
    tick();
    check("irq_cleared", 32'(irq), 32'd0);
    check_frame(8'h0F, 1, 1, 10, -1, 1'b0, 16'h0, 16'h0);
    check("irq_entering_idle", 32'(irq), 32'd0);
    tick();
    check("irq_after_idle", 32'(irq), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
